// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front end.
// Holds the zero-pad FSM state encoding and column counter sizing.
package conv_pkg;
    localparam int PIXEL_DATAW = 8;
    localparam int IMAGE_WIDTH = 512;
    localparam int PAD         = 1;
    localparam int COL_W       = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOP    = 3'd1,
        LEFT   = 3'd2,
        BODY   = 3'd3,
        RIGHT  = 3'd4,
        BOTTOM = 3'd5
    } zpad_state_t;

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
        return col + {{(COL_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/zpad_out_slice.sv
// Output register stage of the zero padder: loads a new beat whenever the
// held beat is gone or accepted, otherwise keeps o_valid/o_x/o_last stable.
module zpad_out_slice #(
    parameter int PIXEL_DATAW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PIXEL_DATAW-1:0] ld_x,
    input  logic                   ld_last,
    input  logic                   i_ready,
    output logic                   adv,
    output logic                   o_valid,
    output logic [PIXEL_DATAW-1:0] o_x,
    output logic                   o_last
);
    assign adv = !o_valid || i_ready;

    // Output beat register; an idle advance clears the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_x     <= {PIXEL_DATAW{1'b0}};
            o_last  <= 1'b0;
        end else if (adv) begin
            o_valid <= load;
            o_x     <= load ? ld_x : {PIXEL_DATAW{1'b0}};
            o_last  <= load && ld_last;
        end else begin
            o_valid <= o_valid;
            o_x     <= o_x;
            o_last  <= o_last;
        end
    end
endmodule

// File: rtl/image_zero_pad.sv
// Zero-pads a raw raster stream to (IMG_W+2) x (H+2) for the 3x3 conv engine.
// Optional framing check on i_last is enabled with `define ZPAD_LAST_CHECK_EN.
module image_zero_pad #(
    parameter int IMG_W       = conv_pkg::IMAGE_WIDTH,
    parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [PIXEL_DATAW-1:0] i_x,
    input  logic                   i_last,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [PIXEL_DATAW-1:0] o_x,
    output logic                   o_last,
    input  logic                   i_ready,
    output logic                   o_err
);
    import conv_pkg::*;

    localparam logic [COL_W-1:0] BODY_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] PAD_LAST  = COL_W'(IMG_W + 2 * PAD - 1);
    localparam logic [COL_W-1:0] COL_ZERO  = {COL_W{1'b0}};

    zpad_state_t            state_r, state_s;
    logic [COL_W-1:0]       col_r, col_s;
    logic                   last_row_r, last_row_s;
    logic                   adv_s;
    logic                   load_s;
    logic [PIXEL_DATAW-1:0] ld_x_s;
    logic                   ld_last_s;
    logic                   ready_s;
    logic                   xfer_s;

    assign o_ready = ready_s;
    assign xfer_s  = i_valid && ready_s;

    // FSM state, column counter and end-of-frame row flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            col_r      <= COL_ZERO;
            last_row_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            last_row_r <= last_row_s;
        end
    end

    // Next-state, column update and beat selection for the output slice.
    always_comb begin
        state_s    = state_r;
        col_s      = col_r;
        last_row_s = last_row_r;
        load_s     = 1'b0;
        ld_x_s     = {PIXEL_DATAW{1'b0}};
        ld_last_s  = 1'b0;
        ready_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // The waking pixel is only observed here, not consumed.
                if (i_valid) begin
                    state_s = TOP;
                    col_s   = COL_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            TOP: begin
                if (adv_s) begin
                    load_s = 1'b1;
                    if (col_r == PAD_LAST) begin
                        state_s = LEFT;
                        col_s   = COL_ZERO;
                    end else begin
                        col_s = col_inc(col_r);
                    end
                end else begin
                    state_s = TOP;
                end
            end
            LEFT: begin
                if (adv_s) begin
                    load_s  = 1'b1;
                    state_s = BODY;
                    col_s   = COL_ZERO;
                end else begin
                    state_s = LEFT;
                end
            end
            BODY: begin
                ready_s = adv_s;
                if (i_valid && adv_s) begin
                    load_s = 1'b1;
                    ld_x_s = i_x;
                    if (col_r == BODY_LAST) begin
                        last_row_s = i_last;
                        state_s    = RIGHT;
                        col_s      = COL_ZERO;
                    end else begin
                        col_s = col_inc(col_r);
                    end
                end else begin
                    state_s = BODY;
                end
            end
            RIGHT: begin
                if (adv_s) begin
                    load_s  = 1'b1;
                    col_s   = COL_ZERO;
                    state_s = last_row_r ? BOTTOM : LEFT;
                end else begin
                    state_s = RIGHT;
                end
            end
            BOTTOM: begin
                if (adv_s) begin
                    load_s = 1'b1;
                    if (col_r == PAD_LAST) begin
                        ld_last_s = 1'b1;
                        state_s   = IDLE;
                        col_s     = COL_ZERO;
                    end else begin
                        col_s = col_inc(col_r);
                    end
                end else begin
                    state_s = BOTTOM;
                end
            end
            default: begin
                state_s = IDLE;
                col_s   = COL_ZERO;
            end
        endcase
    end

    zpad_out_slice #(
        .PIXEL_DATAW(PIXEL_DATAW)
    ) u_out (
        .clk    (clk),
        .reset  (reset),
        .load   (load_s),
        .ld_x   (ld_x_s),
        .ld_last(ld_last_s),
        .i_ready(i_ready),
        .adv    (adv_s),
        .o_valid(o_valid),
        .o_x    (o_x),
        .o_last (o_last)
    );

`ifdef ZPAD_LAST_CHECK_EN
    logic err_r;

    // Sticky flag for i_last seen anywhere but the final column of a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (xfer_s && i_last && (col_r != BODY_LAST)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_err = err_r;
`else
    logic unused_s;
    assign unused_s = xfer_s;
    assign o_err    = 1'b0;
`endif
endmodule

// File: tb/tb_image_zero_pad.sv
// Directed self-checking bench for image_zero_pad with IMG_W=4.
// Expected padded streams are written out by hand from the frame definition.
module tb_image_zero_pad;
    localparam int W = 4;

`ifdef ZPAD_LAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_x = 8'd0;
    logic       i_last = 1'b0;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_x;
    logic       o_last;
    logic       i_ready = 1'b1;
    logic       o_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] src_x[$];
    logic       src_l[$];
    logic [7:0] exp_x[$];
    logic       exp_l[$];
    logic [7:0] got_x[$];
    logic       got_l[$];

    image_zero_pad #(.IMG_W(W), .PIXEL_DATAW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_valid(i_valid),
        .i_x    (i_x),
        .i_last (i_last),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_x    (o_x),
        .o_last (o_last),
        .i_ready(i_ready),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic exp_zeros(input int n, input logic last_at_end);
        for (int k = 0; k < n; k++) begin
            exp_x.push_back(8'd0);
            exp_l.push_back(last_at_end && (k == n - 1));
        end
    endtask

    task automatic exp_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        exp_x.push_back(8'd0); exp_l.push_back(1'b0);
        exp_x.push_back(a);    exp_l.push_back(1'b0);
        exp_x.push_back(b);    exp_l.push_back(1'b0);
        exp_x.push_back(c);    exp_l.push_back(1'b0);
        exp_x.push_back(d);    exp_l.push_back(1'b0);
        exp_x.push_back(8'd0); exp_l.push_back(1'b0);
    endtask

    task automatic src_frame(input logic [7:0] first, input int rows);
        for (int k = 0; k < rows * W; k++) begin
            src_x.push_back(first + 8'(k));
            src_l.push_back(k == rows * W - 1);
        end
    endtask

    // rdy_mode 1 toggles i_ready; gap_mode 1 holds i_valid low 3 cycles before pixel index 2.
    task automatic run(input string tag, input int n_exp, input int rdy_mode, input int gap_mode);
        int idx = 0;
        int cyc = 0;
        int gap_cnt = 0;
        logic held_v = 1'b0;
        logic [7:0] held_x = 8'd0;
        logic held_l = 1'b0;
        logic pend_err = 1'b0;
        got_x.delete();
        got_l.delete();
        while (got_x.size() < n_exp && cyc < 400) begin
            @(negedge clk);
            i_ready = (rdy_mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (gap_mode == 1 && idx == 2 && gap_cnt < 3) begin
                i_valid = 1'b0;
                gap_cnt++;
            end else begin
                i_valid = (idx < src_x.size());
            end
            i_x    = (idx < src_x.size()) ? src_x[idx] : 8'd0;
            i_last = (idx < src_x.size()) ? src_l[idx] : 1'b0;
            #1;
            if (held_v) begin
                chk({tag, "_stall_v"}, {31'd0, o_valid}, 32'd1);
                chk({tag, "_stall_x"}, {24'd0, o_x}, {24'd0, held_x});
                chk({tag, "_stall_l"}, {31'd0, o_last}, {31'd0, held_l});
            end
            if (pend_err) chk({tag, "_err_next"}, {31'd0, o_err}, {31'd0, ERR_EXP});
            held_v = o_valid && !i_ready;
            held_x = o_x;
            held_l = o_last;
            if (o_valid && i_ready) begin
                got_x.push_back(o_x);
                got_l.push_back(o_last);
            end
            pend_err = i_valid && o_ready && i_last && ((idx % W) != W - 1);
            if (i_valid && o_ready) idx++;
            cyc++;
        end
        chk({tag, "_beats"}, got_x.size(), n_exp);
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic compare(input string tag);
        int n;
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        chk({tag, "_explen"}, exp_x.size(), got_x.size());
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_x%0d", tag, k + 1), {24'd0, got_x[k]}, {24'd0, exp_x[k]});
            chk($sformatf("%s_l%0d", tag, k + 1), {31'd0, got_l[k]}, {31'd0, exp_l[k]});
        end
    endtask

    task automatic idle_check(input string tag);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_idle_v"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_idle_rdy"}, {31'd0, o_ready}, 32'd0);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        reset   = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_rst_v"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_rst_x"}, {24'd0, o_x}, 32'd0);
        chk({tag, "_rst_l"}, {31'd0, o_last}, 32'd0);
        chk({tag, "_rst_rdy"}, {31'd0, o_ready}, 32'd0);
        chk({tag, "_rst_err"}, {31'd0, o_err}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic exp_two_row_frame(input logic [7:0] first);
        exp_zeros(6, 1'b0);
        exp_row(first, first + 8'd1, first + 8'd2, first + 8'd3);
        exp_row(first + 8'd4, first + 8'd5, first + 8'd6, first + 8'd7);
        exp_zeros(6, 1'b1);
    endtask

    initial begin
        reset_check("t0");

        // Test 1: 2x4 frame, downstream always ready.
        src_x.delete(); src_l.delete(); src_frame(8'd1, 2);
        exp_x.delete(); exp_l.delete(); exp_two_row_frame(8'd1);
        run("t1", 24, 0, 0);
        compare("t1");
        idle_check("t1");

        // Test 2: i_ready toggles every cycle.
        run("t2", 24, 1, 0);
        compare("t2");
        idle_check("t2");

        // Test 3: 3-cycle i_valid gap mid-row.
        run("t3", 24, 0, 1);
        compare("t3");
        idle_check("t3");

        // Test 4: reset after 10 beats, then 1x4 frame 9..12.
        run("t4a", 10, 0, 0);
        reset_check("t4");
        src_x.delete(); src_l.delete(); src_frame(8'd9, 1);
        exp_x.delete(); exp_l.delete();
        exp_zeros(6, 1'b0);
        exp_row(8'd9, 8'd10, 8'd11, 8'd12);
        exp_zeros(6, 1'b1);
        run("t4", 18, 0, 0);
        compare("t4");
        idle_check("t4");

        // Test 5: two frames with continuous i_valid.
        src_x.delete(); src_l.delete(); src_frame(8'd1, 2); src_frame(8'd21, 2);
        exp_x.delete(); exp_l.delete(); exp_two_row_frame(8'd1); exp_two_row_frame(8'd21);
        run("t5", 48, 0, 0);
        compare("t5");
        idle_check("t5");

        // Test 6: stray i_last at column 1 of row 0 must not end the frame.
        src_x.delete(); src_l.delete(); src_frame(8'd1, 2);
        src_l[1] = 1'b1;
        exp_x.delete(); exp_l.delete(); exp_two_row_frame(8'd1);
        run("t6", 24, 0, 0);
        compare("t6");
        idle_check("t6");
        chk("t6_err_sticky", {31'd0, o_err}, {31'd0, ERR_EXP});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
